// File: rtl/circuit_a_sweep_checker_if.sv
// Purpose: control, expected-table and CircuitA stimulus/response bundle for the sweep checker (log port under CIRCUIT_A_CAPTURE_LOG_EN).
// Latency: pure wiring, no storage.
// Backpressure: none; start is a single-cycle request, ignored by the checker while a sweep runs.
interface circuit_a_sweep_checker_if;
    logic       start;
    logic       exp_we;
    logic [3:0] exp_addr;
    logic [3:0] exp_data;
    logic [3:0] stim;
    logic [3:0] resp;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic       first_fail_valid;
    logic [3:0] first_fail_addr;
`ifdef CIRCUIT_A_CAPTURE_LOG_EN
    logic [3:0] log_addr;
    logic [3:0] log_data;

    modport master (
        output start, exp_we, exp_addr, exp_data, resp, log_addr,
        input  stim, busy, done, pass, err_count, first_fail_valid, first_fail_addr, log_data
    );

    modport slave (
        input  start, exp_we, exp_addr, exp_data, resp, log_addr,
        output stim, busy, done, pass, err_count, first_fail_valid, first_fail_addr, log_data
    );
`else
    modport master (
        output start, exp_we, exp_addr, exp_data, resp,
        input  stim, busy, done, pass, err_count, first_fail_valid, first_fail_addr
    );

    modport slave (
        input  start, exp_we, exp_addr, exp_data, resp,
        output stim, busy, done, pass, err_count, first_fail_valid, first_fail_addr
    );
`endif
endinterface

// File: rtl/circuit_a_sweep_checker.sv
// Purpose: drives codes 0..15 into CircuitA, compares each settled response with a loadable table; optional capture log under CIRCUIT_A_CAPTURE_LOG_EN.
// Latency: sweep takes 16*SETTLE cycles from the start edge; results update on each sampling edge; log read is 1 cycle.
// Backpressure: none; start during a sweep is ignored, table writes during a sweep are dropped.
module circuit_a_sweep_checker #(
    parameter int SETTLE = 2   // cycles each code is held before sampling, 1..15
) (
    input  logic                      clk,
    input  logic                      rst,
    circuit_a_sweep_checker_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state;
    state_t     state_nxt;
    logic       start_sweep;
    logic       sample;
    logic       mismatch;

    logic [3:0] v;
    logic [3:0] s;
    logic [4:0] err_q;
    logic       ff_vld_q;
    logic [3:0] ff_addr_q;

    // Expected responses; deliberately without reset so a table survives rst.
    logic [3:0] exp_tbl [16];

    assign mismatch = (bus.resp != exp_tbl[v]);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: start launches from IDLE/DONE, last sample of code 15 ends the sweep.
    always_comb begin
        state_nxt   = state;
        start_sweep = 1'b0;
        sample      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt   = DRIVE;
                    start_sweep = 1'b1;
                end
            end
            DRIVE: begin
                sample = (s == SETTLE_LAST);
                if (sample && (v == 4'hF)) begin
                    state_nxt = DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Vector/settle counters and result accumulation; v wraps to 0 after code 15.
    always_ff @(posedge clk) begin
        if (rst) begin
            v         <= 4'd0;
            s         <= 4'd0;
            err_q     <= 5'd0;
            ff_vld_q  <= 1'b0;
            ff_addr_q <= 4'd0;
        end else if (start_sweep) begin
            v         <= 4'd0;
            s         <= 4'd0;
            err_q     <= 5'd0;
            ff_vld_q  <= 1'b0;
        end else if (sample) begin
            s <= 4'd0;
            v <= v + 4'd1;
            if (mismatch) begin
                err_q <= err_q + 5'd1;
                if (!ff_vld_q) begin
                    ff_vld_q  <= 1'b1;
                    ff_addr_q <= v;
                end
            end
        end else if (state == DRIVE) begin
            s <= s + 4'd1;
        end
    end

    // Table writes are only accepted while no sweep is reading the table.
    always_ff @(posedge clk) begin
        if (bus.exp_we && (state != DRIVE)) begin
            exp_tbl[bus.exp_addr] <= bus.exp_data;
        end
    end

    assign bus.busy             = (state == DRIVE);
    assign bus.done             = (state == DONE);
    assign bus.stim             = (state == DRIVE) ? v : 4'd0;
    assign bus.err_count        = err_q;
    assign bus.first_fail_valid = ff_vld_q;
    assign bus.first_fail_addr  = ff_addr_q;
    assign bus.pass             = (state == DONE) && (err_q == 5'd0);

`ifdef CIRCUIT_A_CAPTURE_LOG_EN
    logic [3:0] cap_log [16];
    logic [3:0] log_q;

    // Capture every sampled response; cleared on reset and on each sweep start.
    always_ff @(posedge clk) begin
        if (rst || start_sweep) begin
            for (int i = 0; i < 16; i++) begin
                cap_log[i] <= 4'd0;
            end
        end else if (sample) begin
            cap_log[v] <= bus.resp;
        end
    end

    // Registered log read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            log_q <= 4'd0;
        end else begin
            log_q <= cap_log[bus.log_addr];
        end
    end

    assign bus.log_data = log_q;
`endif

endmodule

// File: tb/tb_circuit_a_sweep_checker.sv
// Purpose: self-checking bench; two checkers (SETTLE=2 and SETTLE=1) each beside a CircuitA lookup model.
// Latency: results compared after each sweep against a table/arithmetic reference model.
// Backpressure: not applicable; stimulus driven directly 1 ns after each rising edge.
module tb_circuit_a_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nchecks = 0;
    int nfail   = 0;

    // Per-checker drive and observe arrays (index 0: SETTLE=2, index 1: SETTLE=1).
    logic       rst_d   [2];
    logic       start_d [2];
    logic       we_d    [2];
    logic [3:0] waddr_d [2];
    logic [3:0] wdata_d [2];
    logic [3:0] stim_o  [2];
    logic       busy_o  [2];
    logic       done_o  [2];
    logic       pass_o  [2];
    logic [4:0] err_o   [2];
    logic       ffv_o   [2];
    logic [3:0] ffa_o   [2];
`ifdef CIRCUIT_A_CAPTURE_LOG_EN
    logic [3:0] laddr_d [2];
    logic [3:0] ldata_o [2];
`endif

    // CircuitA model: lookup table, optionally seen through a 1-cycle register.
    logic [3:0] lut     [2][16];
    bit         delayed [2];
    // Reference copy of what each checker's expected table should hold.
    logic [3:0] tbl_m   [2][16];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        circuit_a_sweep_checker_if ifc ();
        logic [3:0] dly_q;

        always @(posedge clk) dly_q <= lut[g][ifc.stim];

        assign ifc.start    = start_d[g];
        assign ifc.exp_we   = we_d[g];
        assign ifc.exp_addr = waddr_d[g];
        assign ifc.exp_data = wdata_d[g];
        assign ifc.resp     = delayed[g] ? dly_q : lut[g][ifc.stim];
        assign stim_o[g]    = ifc.stim;
        assign busy_o[g]    = ifc.busy;
        assign done_o[g]    = ifc.done;
        assign pass_o[g]    = ifc.pass;
        assign err_o[g]     = ifc.err_count;
        assign ffv_o[g]     = ifc.first_fail_valid;
        assign ffa_o[g]     = ifc.first_fail_addr;
`ifdef CIRCUIT_A_CAPTURE_LOG_EN
        assign ifc.log_addr = laddr_d[g];
        assign ldata_o[g]   = ifc.log_data;
`endif

        circuit_a_sweep_checker #(.SETTLE(g == 0 ? 2 : 1)) dut (
            .clk (clk),
            .rst (rst_d[g]),
            .bus (ifc)
        );
    end

    function automatic int settle_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response the checker should see for code k: with a registered CircuitA and
    // one-cycle hold, code k sees the previous code's answer (code 0 sees the
    // answer to the 0 held on stim before the sweep).
    function automatic logic [3:0] seen(input int d, input int k);
        if (delayed[d] && settle_of(d) == 1) begin
            return (k == 0) ? lut[d][0] : lut[d][k-1];
        end
        return lut[d][k];
    endfunction

    task automatic check_results(input int d);
        int e;
        int ff;
        e  = 0;
        ff = -1;
        for (int k = 0; k < 16; k++) begin
            if (seen(d, k) != tbl_m[d][k]) begin
                e++;
                if (ff < 0) ff = k;
            end
        end
        chk("err_count", err_o[d], e);
        chk("ff_valid", ffv_o[d], (ff >= 0) ? 1 : 0);
        if (ff >= 0) chk("ff_addr", ffa_o[d], ff);
        chk("pass", pass_o[d], (e == 0) ? 1 : 0);
        chk("done_end", done_o[d], 1);
        chk("busy_end", busy_o[d], 0);
        chk("stim_end", stim_o[d], 0);
    endtask

    task automatic do_reset(input int d);
        rst_d[d] = 1'b1;
        tick();
        tick();
        chk("rst_stim", stim_o[d], 0);
        chk("rst_busy", busy_o[d], 0);
        chk("rst_done", done_o[d], 0);
        chk("rst_pass", pass_o[d], 0);
        chk("rst_err", err_o[d], 0);
        chk("rst_ffv", ffv_o[d], 0);
        chk("rst_ffa", ffa_o[d], 0);
`ifdef CIRCUIT_A_CAPTURE_LOG_EN
        chk("rst_log", ldata_o[d], 0);
`endif
        rst_d[d] = 1'b0;
    endtask

    task automatic wr(input int d, input int a, input logic [3:0] val);
        we_d[d]    = 1'b1;
        waddr_d[d] = 4'(a);
        wdata_d[d] = val;
        tick();
        we_d[d]    = 1'b0;
        tbl_m[d][a] = val;
    endtask

    task automatic load_all(input int d);
        for (int i = 0; i < 16; i++) wr(d, i, tbl_m[d][i]);
    endtask

    // One sweep. poke_*_vec >= 0 injects a start pulse / table write while that code is driven.
    task automatic run_sweep(input int d, input int poke_start_vec, input int poke_we_vec,
                             input bit wr0, input logic [3:0] wr0_val);
        int c;
        int st;
        st = settle_of(d);
        start_d[d] = 1'b1;
        if (wr0) begin
            we_d[d]    = 1'b1;
            waddr_d[d] = 4'd0;
            wdata_d[d] = wr0_val;
            tbl_m[d][0] = wr0_val;
        end
        tick();
        start_d[d] = 1'b0;
        we_d[d]    = 1'b0;
        chk("busy_e0", busy_o[d], 1);
        chk("stim_e0", stim_o[d], 0);
        chk("err_e0", err_o[d], 0);
        c = 0;
        while (c < 40 * st) begin
            if (poke_start_vec >= 0 && c == poke_start_vec * st) start_d[d] = 1'b1;
            if (poke_we_vec >= 0 && c == poke_we_vec * st) begin
                we_d[d]    = 1'b1;
                waddr_d[d] = 4'hF;
                wdata_d[d] = ~tbl_m[d][15];
            end
            tick();
            c++;
            start_d[d] = 1'b0;
            we_d[d]    = 1'b0;
            if (done_o[d]) break;
            chk("stim_seq", stim_o[d], c / st);
        end
        chk("done_lat", c, 16 * st);
        check_results(d);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_d[d] = 1'b1; start_d[d] = 1'b0; we_d[d] = 1'b0;
            waddr_d[d] = 4'd0; wdata_d[d] = 4'd0; delayed[d] = 1'b0;
`ifdef CIRCUIT_A_CAPTURE_LOG_EN
            laddr_d[d] = 4'd0;
`endif
            for (int i = 0; i < 16; i++) begin
                lut[d][i]   = ~4'(i);
                tbl_m[d][i] = ~4'(i);
            end
        end

        for (int d = 0; d < 2; d++) begin
            // Reset values, then a table load that must survive a second reset,
            // then a start on the very first cycle out of reset.
            do_reset(d);
            load_all(d);
            do_reset(d);
            run_sweep(d, -1, -1, 1'b0, 4'd0);

`ifdef CIRCUIT_A_CAPTURE_LOG_EN
            laddr_d[d] = 4'd3;
            tick();
            chk("log_rd3", ldata_o[d], 4'hC);
            start_d[d] = 1'b1;
            tick();
            start_d[d] = 1'b0;
            tick();
            chk("log_clr", ldata_o[d], 0);
            for (int i = 0; i < 40 && !done_o[d]; i++) tick();
            tick();
            chk("log_refill", ldata_o[d], 4'hC);
`endif

            // Injected faults at codes 5 and 12.
            wr(d, 5, 4'h0);
            wr(d, 12, 4'h0);
            run_sweep(d, -1, -1, 1'b0, 4'd0);

            // Start and table write during the sweep are both ignored.
            wr(d, 5, 4'hA);
            wr(d, 12, 4'h3);
            run_sweep(d, 7, 7, 1'b0, 4'd0);

            // Table write on the start edge is seen by code 0.
            run_sweep(d, -1, -1, 1'b1, 4'h3);
            wr(d, 0, 4'hF);

            // Reset at code 9 discards partial results (one mismatch already at code 5).
            wr(d, 5, 4'h0);
            start_d[d] = 1'b1;
            tick();
            start_d[d] = 1'b0;
            for (int i = 0; i < 9 * settle_of(d); i++) tick();
            chk("mid_err_pre", err_o[d], 1);
            rst_d[d] = 1'b1;
            tick();
            rst_d[d] = 1'b0;
            chk("mid_rst_err", err_o[d], 0);
            chk("mid_rst_done", done_o[d], 0);
            chk("mid_rst_busy", busy_o[d], 0);
            chk("mid_rst_ffv", ffv_o[d], 0);
            wr(d, 5, 4'hA);

            // Registered CircuitA: fails on every shifted code at SETTLE=1, clean at SETTLE=2.
            delayed[d] = 1'b1;
            run_sweep(d, -1, -1, 1'b0, 4'd0);
            delayed[d] = 1'b0;
        end

        // Randomised CircuitA functions, table corruptions and control pokes.
        for (int it = 0; it < 6; it++) begin
            for (int d = 0; d < 2; d++) begin
                delayed[d] = ($urandom_range(0, 1) == 1);
                for (int i = 0; i < 16; i++) begin
                    lut[d][i]   = 4'($urandom_range(0, 15));
                    tbl_m[d][i] = lut[d][i];
                    if ($urandom_range(0, 5) == 0) tbl_m[d][i] = lut[d][i] ^ 4'($urandom_range(1, 15));
                end
                load_all(d);
                run_sweep(d, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1,
                          ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1,
                          1'b0, 4'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
